// File: rtl/mem_core.sv
// 16-word FIFO data memory: MemWrite appends at the write pointer, MemRead pops the oldest word.
// Read data is registered and held between reads; full/empty stay internal.
module mem_core #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemWrite,
    input  logic             MemRead,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wp;
    logic [ADDR_W-1:0] rp;
    logic [CNT_W-1:0]  count;

    logic empty_c;
    logic full_c;
    logic wr_en_c;
    logic rd_en_c;

    // Both strobes are qualified against the pre-edge occupancy.
    always_comb begin
        empty_c = (count == '0);
        full_c  = (count == CNT_W'(DEPTH));
        wr_en_c = MemWrite && !full_c;
        rd_en_c = MemRead && !empty_c;
    end

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (!reset && wr_en_c) begin
            mem[wp] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            data_out <= '0;
        end else begin
            if (wr_en_c) begin
                wp <= wp + ADDR_W'(1);
            end
            if (rd_en_c) begin
                data_out <= mem[rp];
                rp       <= rp + ADDR_W'(1);
            end
            case ({wr_en_c, rd_en_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_core.sv
// Scoreboard bench for mem_core: a queue-based reference predicts data_out and occupancy
// after every edge; a negedge monitor pops and compares.
module tb_mem_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic        MemRead;
    logic [15:0] data_in;
    logic [15:0] data_out;

    int checks = 0;
    int errors = 0;
    int step   = 0;

    typedef struct {
        logic [15:0] data;
        int          cnt;
        int          step;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] model_q[$];
    logic [15:0] model_out = 16'h0000;

    mem_core dut (
        .clk      (clk),
        .reset    (reset),
        .MemWrite (MemWrite),
        .MemRead  (MemRead),
        .data_in  (data_in),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    // Reference: a plain FIFO of depth 16 with read-then-write decided on pre-edge size.
    task automatic cycle(input logic rst, input logic wr, input logic rd, input logic [15:0] din);
        int   pre;
        exp_t e;
        reset    = rst;
        MemWrite = wr;
        MemRead  = rd;
        data_in  = din;
        @(posedge clk);
        if (rst) begin
            model_q.delete();
            model_out = 16'h0000;
        end else begin
            pre = model_q.size();
            if (rd && pre > 0) model_out = model_q.pop_front();
            if (wr && pre < 16) model_q.push_back(din);
        end
        e.data = model_out;
        e.cnt  = model_q.size();
        e.step = step;
        sb_q.push_back(e);
        #1;
    endtask

    // Monitor: one expectation per edge, checked half a cycle later.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (data_out !== e.data) begin
                    errors++;
                    $display("FAIL data_out step %0d: got %h expected %h", e.step, data_out, e.data);
                end
                checks++;
                if (int'(dut.count) != e.cnt) begin
                    errors++;
                    $display("FAIL count step %0d: got %0d expected %0d", e.step, dut.count, e.cnt);
                end
            end
        end
    end

    initial begin
        reset = 1'b0; MemWrite = 1'b0; MemRead = 1'b0; data_in = 16'h0;
        #1;

        // Reset, write 8888, read it back
        step = 1;
        cycle(1, 0, 0, 16'h0);
        cycle(0, 1, 0, 16'h8888);
        cycle(0, 0, 1, 16'h0);

        // Combined read+write on empty: only the write lands
        step = 2;
        cycle(0, 1, 1, 16'hADAD);
        cycle(0, 0, 1, 16'h0);

        // Reads on empty hold data_out
        step = 3;
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 16'h0);

        // Fill, overflow attempt, drain past empty
        step = 4;
        for (int i = 1; i <= 16; i++) cycle(0, 1, 0, 16'(i));
        cycle(0, 1, 0, 16'hFFFF);
        cycle(0, 1, 1, 16'hEEEE);
        cycle(0, 1, 0, 16'h0011);
        for (int i = 0; i < 17; i++) cycle(0, 0, 1, 16'h0);

        // Steady occupancy of 8 under simultaneous access, wrapping pointers
        step = 5;
        for (int i = 0; i < 8; i++) cycle(0, 1, 0, 16'($urandom_range(0, 16'hFFFF)));
        for (int i = 0; i < 40; i++) cycle(0, 1, 1, 16'($urandom_range(0, 16'hFFFF)));
        for (int i = 0; i < 9; i++) cycle(0, 0, 1, 16'h0);

        // Mid-stream reset discards queued words
        step = 6;
        cycle(0, 1, 0, 16'h1111);
        cycle(0, 1, 0, 16'h2222);
        cycle(1, 0, 0, 16'h0);
        cycle(0, 0, 1, 16'h0);

        // Random strobes with occasional reset
        step = 7;
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 35)),
                  ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 70)),
                  16'($urandom_range(0, 16'hFFFF)));
        end
        cycle(0, 0, 0, 16'h0);

        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
